// File: rtl/cacheline_adaptor.sv
// Line/burst bridge between the cache data array and physical memory.
// Fills assemble NUM_BEATS memory beats into one line; writebacks split a line into beats.
module cacheline_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int s_burst  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    output logic                resp_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    output logic [s_burst-1:0]  burst_o,
    input  logic [s_burst-1:0]  burst_i,
    input  logic                resp_i
);

    localparam int NUM_BEATS = s_line / s_burst;
    localparam int CW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [s_line-1:0]   buffer_q, buffer_d;
    logic [31:0]         address_q, address_d;
    logic                last_beat_s;

    assign last_beat_s = (count_q == CW'(NUM_BEATS - 1));

    // State, beat counter, line buffer and latched address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            buffer_q  <= '0;
            address_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            buffer_q  <= buffer_d;
            address_q <= address_d;
        end
    end

    // Next-state logic; a write request wins over a simultaneous read.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buffer_d  = buffer_q;
        address_d = address_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    buffer_d  = line_i;
                    address_d = address_i & ADDR_MASK;
                    count_d   = '0;
                    state_d   = WRITE;
                end else if (read_i) begin
                    address_d = address_i & ADDR_MASK;
                    count_d   = '0;
                    state_d   = READ;
                end else begin
                    state_d   = IDLE;
                end
            end
            READ: begin
                if (resp_i) begin
                    for (int i = 0; i < NUM_BEATS; i++) begin
                        if (count_q == CW'(i)) begin
                            buffer_d[i*s_burst +: s_burst] = burst_i;
                        end else begin
                            buffer_d[i*s_burst +: s_burst] = buffer_q[i*s_burst +: s_burst];
                        end
                    end
                    if (last_beat_s) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    count_d = count_q;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    if (last_beat_s) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    count_d = count_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Current write beat, selected by the beat counter; zero outside writebacks.
    always_comb begin
        burst_o = '0;
        if (state_q == WRITE) begin
            for (int i = 0; i < NUM_BEATS; i++) begin
                if (count_q == CW'(i)) begin
                    burst_o = buffer_q[i*s_burst +: s_burst];
                end else begin
                    burst_o = burst_o;
                end
            end
        end else begin
            burst_o = '0;
        end
    end

    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign line_o    = buffer_q;
    assign address_o = address_q;

endmodule
